dsp_path_cfg_sequencer: RTL and testbench

Configuration sequencer in front of the DDC + averager datapath.
- Holds a host-writable shadow set of FIR coefficients and samples the decimation and averaging settings when the host requests an update.
- On a start pulse it replays the whole set onto the datapath's FIR, decimation and averager command ports in a fixed order, then waits a settle interval before reporting done.
- ADC sample valids are gated for the entire update, so no sample is processed with a half-updated configuration.

---
 rtl/dsp_path_cfg_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_dsp_path_cfg_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_path_cfg_sequencer.sv
// Replays the shadow FIR coefficient set plus latched decimation/averaging settings
// onto the datapath command ports, holding off ADC valids until the update has settled.
//
// state       | meaning
// S_IDLE      | waiting for start; shadow writes accepted, ADC valids pass
// S_LOAD_FIR  | one FIR coefficient command per cycle, ascending index
// S_LOAD_DECI | single decimation command
// S_LOAD_AVG  | single averager command (skipped when averaging is disabled)
// S_SETTLE    | command-free settle interval, down-counter to terminal count
// S_DONE      | one-cycle completion pulse
module dsp_path_cfg_sequencer #(
    parameter int INT_NUMBER_OF_TAPS   = 15,
    parameter int INT_COEF_WIDTH       = 15,
    parameter int INT_MAX_DOWNSAMPLING = 5,
    parameter int INT_MAX_AVERAGE_BY   = 5,
    parameter int INT_SETTLE_CYCLES    = 8,
    localparam int TW = (INT_NUMBER_OF_TAPS > 1) ? $clog2(INT_NUMBER_OF_TAPS) : 1,
    localparam int DW = (INT_MAX_DOWNSAMPLING > 1) ? $clog2(INT_MAX_DOWNSAMPLING) : 1,
    localparam int AW = (INT_MAX_AVERAGE_BY > 1) ? $clog2(INT_MAX_AVERAGE_BY) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_coef_wr_valid,
    input  logic [TW-1:0]                    i_coef_wr_addr,
    input  logic signed [INT_COEF_WIDTH-1:0] i_coef_wr_data,
    input  logic [DW-1:0]                    i_cfg_deci,
    input  logic [AW-1:0]                    i_cfg_avg,
    input  logic                             i_start,
    input  logic                             i_adc_valid,
    output logic                             o_adc_valid,
    output logic                             o_fir_cmd_valid,
    output logic [TW-1:0]                    o_fir_cmd_coeffsel,
    output logic signed [INT_COEF_WIDTH-1:0] o_fir_cmd_data,
    output logic                             o_deci_cmd_valid,
    output logic [DW-1:0]                    o_deci_cmd_data,
    output logic                             o_avg_cmd_valid,
    output logic [AW-1:0]                    o_avg_cmd_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_wr_err
);

    localparam int SW = (INT_SETTLE_CYCLES > 1) ? $clog2(INT_SETTLE_CYCLES) : 1;
    localparam logic [TW:0]   LP_TAPS       = (TW+1)'(INT_NUMBER_OF_TAPS);
    localparam logic [TW-1:0] LP_TAP_LAST   = TW'(INT_NUMBER_OF_TAPS - 1);
    localparam logic [SW-1:0] LP_SETTLE_TC  = SW'(INT_SETTLE_CYCLES - 1);
    localparam bit            LP_HAS_AVG    = (INT_MAX_AVERAGE_BY > 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FIR,
        S_LOAD_DECI,
        S_LOAD_AVG,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                            r_state, w_state_nxt;
    logic [TW-1:0]                     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [SW-1:0]                     r_settle, w_settle_nxt;
    logic [DW-1:0]                     r_deci, w_deci_nxt;
    logic [AW-1:0]                     r_avg, w_avg_nxt;
    logic signed [INT_COEF_WIDTH-1:0]  r_shadow [INT_NUMBER_OF_TAPS];

    logic                              r_fir_valid, w_fir_valid_nxt;
    logic [TW-1:0]                     r_fir_sel, w_fir_sel_nxt;
    logic signed [INT_COEF_WIDTH-1:0]  r_fir_data, w_fir_data_nxt;
    logic                              r_deci_valid, w_deci_valid_nxt;
    logic [DW-1:0]                     r_deci_data, w_deci_data_nxt;
    logic                              r_avg_valid, w_avg_valid_nxt;
    logic [AW-1:0]                     r_avg_data, w_avg_data_nxt;
    logic                              r_done, w_done_nxt;
    logic                              r_wr_err;
    logic                              w_wr_ok, w_wr_err;

    always_comb begin
        w_wr_ok  = i_coef_wr_valid && (r_state == S_IDLE) && ({1'b0, i_coef_wr_addr} < LP_TAPS);
        w_wr_err = i_coef_wr_valid && !w_wr_ok;
        w_cnt_inc = r_cnt + 1'b1;

        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_settle_nxt     = r_settle;
        w_deci_nxt       = r_deci;
        w_avg_nxt        = r_avg;
        w_fir_valid_nxt  = 1'b0;
        w_fir_sel_nxt    = r_fir_sel;
        w_fir_data_nxt   = r_fir_data;
        w_deci_valid_nxt = 1'b0;
        w_deci_data_nxt  = r_deci_data;
        w_avg_valid_nxt  = 1'b0;
        w_avg_data_nxt   = r_avg_data;
        w_done_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt     = S_LOAD_FIR;
                    w_cnt_nxt       = '0;
                    w_deci_nxt      = i_cfg_deci;
                    w_avg_nxt       = i_cfg_avg;
                    w_fir_valid_nxt = 1'b1;
                    w_fir_sel_nxt   = '0;
                    // A same-cycle write to index 0 must be replayed, so bypass the shadow.
                    w_fir_data_nxt  = (w_wr_ok && (i_coef_wr_addr == '0)) ? i_coef_wr_data
                                                                          : r_shadow[0];
                end
            end
            S_LOAD_FIR: begin
                if (r_cnt == LP_TAP_LAST) begin
                    w_state_nxt      = S_LOAD_DECI;
                    w_deci_valid_nxt = 1'b1;
                    w_deci_data_nxt  = r_deci;
                end else begin
                    w_cnt_nxt       = w_cnt_inc;
                    w_fir_valid_nxt = 1'b1;
                    w_fir_sel_nxt   = w_cnt_inc;
                    w_fir_data_nxt  = r_shadow[w_cnt_inc];
                end
            end
            S_LOAD_DECI: begin
                if (LP_HAS_AVG) begin
                    w_state_nxt     = S_LOAD_AVG;
                    w_avg_valid_nxt = 1'b1;
                    w_avg_data_nxt  = r_avg;
                end else begin
                    w_state_nxt  = S_SETTLE;
                    w_settle_nxt = LP_SETTLE_TC;
                end
            end
            S_LOAD_AVG: begin
                w_state_nxt  = S_SETTLE;
                w_settle_nxt = LP_SETTLE_TC;
            end
            S_SETTLE: begin
                if (r_settle == '0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_settle_nxt = r_settle - 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_settle     <= '0;
            r_deci       <= '0;
            r_avg        <= '0;
            r_fir_valid  <= 1'b0;
            r_fir_sel    <= '0;
            r_fir_data   <= '0;
            r_deci_valid <= 1'b0;
            r_deci_data  <= '0;
            r_avg_valid  <= 1'b0;
            r_avg_data   <= '0;
            r_done       <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_settle     <= w_settle_nxt;
            r_deci       <= w_deci_nxt;
            r_avg        <= w_avg_nxt;
            r_fir_valid  <= w_fir_valid_nxt;
            r_fir_sel    <= w_fir_sel_nxt;
            r_fir_data   <= w_fir_data_nxt;
            r_deci_valid <= w_deci_valid_nxt;
            r_deci_data  <= w_deci_data_nxt;
            r_avg_valid  <= w_avg_valid_nxt;
            r_avg_data   <= w_avg_data_nxt;
            r_done       <= w_done_nxt;
            r_wr_err     <= w_wr_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INT_NUMBER_OF_TAPS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_shadow[i_coef_wr_addr] <= i_coef_wr_data;
        end
    end

    // Valid gating stays combinational so the start cycle's sample still gets through.
    assign o_adc_valid        = i_adc_valid && (r_state == S_IDLE) && !rst;
    assign o_fir_cmd_valid    = r_fir_valid;
    assign o_fir_cmd_coeffsel = r_fir_sel;
    assign o_fir_cmd_data     = r_fir_data;
    assign o_deci_cmd_valid   = r_deci_valid;
    assign o_deci_cmd_data    = r_deci_data;
    assign o_avg_cmd_valid    = r_avg_valid;
    assign o_avg_cmd_data     = r_avg_data;
    assign o_busy             = (r_state != S_IDLE);
    assign o_done             = r_done;
    assign o_wr_err           = r_wr_err;

endmodule

// File: tb/tb_dsp_path_cfg_sequencer.sv
// Randomized bench for dsp_path_cfg_sequencer against a timeline model: each accepted
// start opens a numbered sequence whose cycle offset alone defines the expected outputs.
module tb_dsp_path_cfg_sequencer;

    localparam int TAPS = 15;
    localparam int CW   = 15;
    localparam int S    = 8;
    localparam int LEN  = TAPS + 3 + S;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_coef_wr_valid = 1'b0;
    logic [3:0]           i_coef_wr_addr = '0;
    logic signed [CW-1:0] i_coef_wr_data = '0;
    logic [2:0]           i_cfg_deci = '0;
    logic [2:0]           i_cfg_avg = '0;
    logic                 i_start = 1'b0;
    logic                 i_adc_valid = 1'b0;
    logic                 o_adc_valid;
    logic                 o_fir_cmd_valid;
    logic [3:0]           o_fir_cmd_coeffsel;
    logic signed [CW-1:0] o_fir_cmd_data;
    logic                 o_deci_cmd_valid;
    logic [2:0]           o_deci_cmd_data;
    logic                 o_avg_cmd_valid;
    logic [2:0]           o_avg_cmd_data;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_wr_err;

    dsp_path_cfg_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .i_coef_wr_valid    (i_coef_wr_valid),
        .i_coef_wr_addr     (i_coef_wr_addr),
        .i_coef_wr_data     (i_coef_wr_data),
        .i_cfg_deci         (i_cfg_deci),
        .i_cfg_avg          (i_cfg_avg),
        .i_start            (i_start),
        .i_adc_valid        (i_adc_valid),
        .o_adc_valid        (o_adc_valid),
        .o_fir_cmd_valid    (o_fir_cmd_valid),
        .o_fir_cmd_coeffsel (o_fir_cmd_coeffsel),
        .o_fir_cmd_data     (o_fir_cmd_data),
        .o_deci_cmd_valid   (o_deci_cmd_valid),
        .o_deci_cmd_data    (o_deci_cmd_data),
        .o_avg_cmd_valid    (o_avg_cmd_valid),
        .o_avg_cmd_data     (o_avg_cmd_data),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_wr_err           (o_wr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // model: m_t is the offset inside the running sequence, 0 when idle
    int m_t = 0;
    int m_shadow [TAPS];
    int m_snap   [TAPS];
    int m_deci = 0, m_avg = 0;
    int m_last_sel = 0, m_last_data = 0, m_last_deci = 0, m_last_avg = 0;
    int m_wr_err = 0;

    int cnt_drop = 0, cnt_done = 0, cnt_fir = 0, cnt_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, $signed(act), $signed(exp));
    endtask

    task automatic check_cycle();
        chk("busy_idle", 32'(o_busy), 32'(m_t != 0 && m_t != LEN) | 32'(o_busy && m_t == LEN));
        chk("fir_valid", 32'(o_fir_cmd_valid), 32'(m_t >= 1 && m_t <= TAPS));
        chk("fir_sel", 32'(o_fir_cmd_coeffsel), 32'(m_last_sel));
        chk("fir_data", 32'($signed(o_fir_cmd_data)), 32'(m_last_data));
        chk("deci_valid", 32'(o_deci_cmd_valid), 32'(m_t == TAPS + 1));
        chk("deci_data", 32'(o_deci_cmd_data), 32'(m_last_deci));
        chk("avg_valid", 32'(o_avg_cmd_valid), 32'(m_t == TAPS + 2));
        chk("avg_data", 32'(o_avg_cmd_data), 32'(m_last_avg));
        chk("done", 32'(o_done), 32'(m_t == LEN));
        chk("wr_err", 32'(o_wr_err), 32'(m_wr_err));
        chk("adc_valid", 32'(o_adc_valid), 32'(i_adc_valid && m_t == 0 && !rst));
        if (i_adc_valid && !o_adc_valid) cnt_drop++;
        if (o_done) cnt_done++;
        if (o_fir_cmd_valid) cnt_fir++;
        if (o_wr_err) cnt_err++;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_t = 0;
            foreach (m_shadow[i]) m_shadow[i] = 0;
            m_deci = 0; m_avg = 0; m_wr_err = 0;
            m_last_sel = 0; m_last_data = 0; m_last_deci = 0; m_last_avg = 0;
        end else begin
            m_wr_err = int'(i_coef_wr_valid && (m_t != 0 || i_coef_wr_addr >= TAPS));
            if (m_t == 0) begin
                if (i_coef_wr_valid && i_coef_wr_addr < TAPS)
                    m_shadow[i_coef_wr_addr] = int'(i_coef_wr_data);
                if (i_start) begin
                    m_t = 1;
                    m_snap = m_shadow;
                    m_deci = int'(i_cfg_deci);
                    m_avg = int'(i_cfg_avg);
                end
            end else if (m_t == LEN) begin
                m_t = 0;
            end else begin
                m_t++;
            end
            if (m_t >= 1 && m_t <= TAPS) begin
                m_last_sel = m_t - 1;
                m_last_data = m_snap[m_t - 1];
            end
            if (m_t == TAPS + 1) m_last_deci = m_deci;
            if (m_t == TAPS + 2) m_last_avg = m_avg;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clr_counts();
        cnt_drop = 0; cnt_done = 0; cnt_fir = 0; cnt_err = 0;
    endtask

    task automatic run_seq(input int n);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        foreach (m_shadow[i]) begin m_shadow[i] = 0; m_snap[i] = 0; end
        i_adc_valid = 1'b1;
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // shadow load, deci=4, avg=3, ADC valid held high
        for (int k = 0; k < TAPS; k++) begin
            i_coef_wr_valid = 1'b1;
            i_coef_wr_addr  = 4'(k);
            i_coef_wr_data  = CW'(100 * k - 700);
            tick();
        end
        i_coef_wr_valid = 1'b0;
        i_cfg_deci = 3'd4;
        i_cfg_avg  = 3'd3;
        clr_counts();
        run_seq(30);
        chk("s1_drops", 32'(cnt_drop), 32'(LEN));
        chk("s1_done_cnt", 32'(cnt_done), 32'd1);
        chk("s1_fir_cnt", 32'(cnt_fir), 32'(TAPS));

        // start pulsed mid-sequence is ignored
        clr_counts();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (25) tick();
        chk("s3_done_cnt", 32'(cnt_done), 32'd1);
        chk("s3_fir_cnt", 32'(cnt_fir), 32'(TAPS));

        // rejected writes: busy, then out-of-range index
        clr_counts();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (2) tick();
        i_coef_wr_valid = 1'b1; i_coef_wr_addr = 4'd3; i_coef_wr_data = 15'sd1234;
        tick();
        i_coef_wr_valid = 1'b0;
        repeat (30) tick();
        i_coef_wr_valid = 1'b1; i_coef_wr_addr = 4'd15; i_coef_wr_data = 15'sd99;
        tick();
        i_coef_wr_valid = 1'b0;
        tick();
        chk("s4_err_cnt", 32'(cnt_err), 32'd2);
        run_seq(30);

        // reset in the middle of the FIR load
        i_adc_valid = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        clr_counts();
        run_seq(30);
        chk("s5_fir_cnt", 32'(cnt_fir), 32'(TAPS));

        // same-cycle write to index 0 and start
        i_coef_wr_valid = 1'b1; i_coef_wr_addr = 4'd0; i_coef_wr_data = -15'sd5;
        i_start = 1'b1;
        tick();
        i_coef_wr_valid = 1'b0;
        i_start = 1'b0;
        repeat (30) tick();

        // start held high re-triggers back to back
        clr_counts();
        i_adc_valid = 1'b1;
        i_start = 1'b1;
        repeat (2 * (LEN + 1)) tick();
        i_start = 1'b0;
        repeat (30) tick();
        chk("held_done_cnt", 32'(cnt_done), 32'd2);

        // random traffic
        repeat (1500) begin
            i_coef_wr_valid = ($urandom % 3) == 0;
            i_coef_wr_addr  = 4'($urandom_range(0, 15));
            i_coef_wr_data  = CW'(int'($urandom_range(0, 32767)) - 16384);
            i_cfg_deci      = 3'($urandom_range(0, 7));
            i_cfg_avg       = 3'($urandom_range(0, 7));
            i_start         = ($urandom % 16) == 0;
            i_adc_valid     = $urandom_range(0, 1) == 1;
            rst             = ($urandom % 200) == 0;
            tick();
        end
        rst = 1'b0;
        i_start = 1'b0;
        i_coef_wr_valid = 1'b0;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
